seq_concat_mac: RTL

- Sequential, parametrised gate pre-activation unit for the GRU/LSTM datapath.
- Computes out = sum(W0[i]*x[i]) + sum(W1[j]*h[j]) + b over a concatenated {x, h} vector. Elements arrive serially, one (data, weight) pair per handshake.
- One shared multiplier, a wide internal accumulator, then a single round of bias add and saturation.
- Sits between the weight/state buffers and the activation (sigmoid/tanh) stage. Replaces the single-element combinational concat-multiply-add.

---
 rtl/seq_concat_mac_if.sv | 32 +++
 rtl/seq_concat_mac.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_concat_mac_if.sv
// Element/result handshake bundle for seq_concat_mac: start+bias, serial
// (data, weight) element stream, and the held result with overflow flag.
interface seq_concat_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_X        = 4,
  parameter int N_H        = 4
);
  localparam int IDX_W = $clog2(N_X + N_H);

  logic                  start;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] in_weight;
  logic                  seg_h;
  logic [IDX_W-1:0]      elem_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  ovf;

  modport master (
    output start, b_in, in_valid, in_data, in_weight, out_ready,
    input  in_ready, seg_h, elem_idx, out_valid, out, ovf
  );

  modport slave (
    input  start, b_in, in_valid, in_data, in_weight, out_ready,
    output in_ready, seg_h, elem_idx, out_valid, out, ovf
  );
endinterface

// File: rtl/seq_concat_mac.sv
// Serial GRU/LSTM gate pre-activation: sum(W0*x) + sum(W1*h) + b over N_X+N_H
// elements through one multiplier; bias add and saturate/wrap in a single cycle.
module seq_concat_mac #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5,
  parameter int N_X         = 4,
  parameter int N_H         = 4,
  parameter bit SATURATE    = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seq_concat_mac_if.slave bus
);
  localparam int N     = N_X + N_H;
  localparam int IDX_W = $clog2(N);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_BIAS  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] NX_IDX   = IDX_W'(N_X);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]   SAT_HI = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]   SAT_LO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state;
  logic [IDX_W-1:0]             cnt;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] bias;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic [DATA_WIDTH-1:0]        out_r;
  logic                         ovf_r;

  logic signed [PW-1:0]         prod_full;
  logic signed [PW-1:0]         prod_shr;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      sum;
  logic                         too_hi;
  logic                         too_lo;
  logic [DATA_WIDTH-1:0]        out_next;
  logic                         fire;

  // Arithmetic shift gives floor rounding on the fractional bits.
  assign prod_full = $signed(bus.in_data) * $signed(bus.in_weight);
  assign prod_shr  = prod_full >>> FRACT_WIDTH;
  assign prod_ext  = {{(ACC_W-PW){prod_shr[PW-1]}}, prod_shr};

  assign sum    = acc + {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign too_hi = sum > MAX_V;
  assign too_lo = sum < MIN_V;

  always_comb begin
    out_next = sum[DATA_WIDTH-1:0];
    if (SATURATE) begin
      if (too_hi)      out_next = SAT_HI;
      else if (too_lo) out_next = SAT_LO;
    end
  end

  assign fire = bus.in_valid & in_ready_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      bias        <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bias       <= $signed(bus.b_in);
            acc        <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b1;
            state      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (fire) begin
            acc <= acc + prod_ext;
            // Counter parks at 0 after the last element so seg_h/elem_idx idle low.
            if (cnt == LAST_IDX) begin
              cnt        <= '0;
              in_ready_r <= 1'b0;
              state      <= S_BIAS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_BIAS: begin
          out_r       <= out_next;
          ovf_r       <= too_hi | too_lo;
          out_valid_r <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.seg_h     = (cnt >= NX_IDX);
  assign bus.elem_idx  = cnt;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.ovf       = ovf_r;
endmodule
